// File: rtl/clock_gen_pkg.sv
// Shared types for the clock generation subsystem: scheduler states and
// the smallest divide ratio that still yields a non-degenerate clock.
package clock_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int MIN_RATIO = 2;

endpackage

// File: rtl/div_period_cnt.sv
// Period counter for the divided clock: counts 0..ratio-1, flags the last
// cycle of a period and produces the registered clk_out/tick waveform.
module div_period_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             run,
  input  logic [CNT_W-1:0] ratio,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   half;

  // One extra bit keeps cnt+1 from wrapping when ratio is the maximum value.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign half    = {2'b00, ratio[CNT_W-1:1]};
  assign wrap    = en && (cnt_q == (ratio - {{(CNT_W-1){1'b0}}, 1'b1}));

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    // A period boundary (or a start from idle) either opens a new period or parks low.
    if (!en || wrap) begin
      cnt_d  = '0;
      tick_d = run;
      clk_d  = run;
    end else begin
      cnt_d  = cnt_inc[CNT_W-1:0];
      clk_d  = (cnt_inc < half);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clock_div_sched.sv
// Runtime-reconfigurable clock divider: accepts ratio updates over a
// valid/ready handshake and applies them only at period boundaries.
module clock_div_sched
  import clock_gen_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] ratio_cur,
  output logic             busy
);

  // Handshake: a ratio transfers on a posedge where cfg_valid && cfg_ready;
  // cfg_ready is low only while a ratio is pending, and the requester holds
  // cfg_valid/cfg_ratio stable until it is taken.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             xfer, ratio_ok, wrap;

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign ratio_ok  = (cfg_ratio >= CNT_W'(MIN_RATIO));

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    err_d   = xfer && !ratio_ok;
    unique case (state_q)
      IDLE: begin
        if (xfer && ratio_ok) ratio_d = cfg_ratio;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (wrap) state_d = run ? RUN : IDLE;
        // A ratio taken on the final cycle of a stopping period goes straight
        // into effect, since there is no further boundary to wait for.
        if (xfer && ratio_ok) begin
          if (wrap && !run) begin
            ratio_d = cfg_ratio;
          end else begin
            pend_d  = cfg_ratio;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          ratio_d = pend_q;
          state_d = run ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ratio_q <= CNT_W'(DEF_RATIO);
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign ratio_cur = ratio_q;
  assign cfg_err   = err_q;

  div_period_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (busy),
    .run     (run),
    .ratio   (ratio_q),
    .wrap    (wrap),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule
